// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file write-back driver.
// Selects ALU, extended load or link result and counts retired instructions.
module wb_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LINK_OFFSET = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic                  in_link,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [1:0]            in_load_size,
  input  logic                  in_load_unsigned,
  input  logic [1:0]            in_byte_off,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]     writedata,
  output logic                  wb_misalign,
  output logic [31:0]           retire_count
);

  logic                  r_valid, r_regwrite, r_memtoreg, r_link, r_unsigned;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]     r_alu, r_mem, r_pc;
  logic [1:0]            r_size, r_off;
  logic [31:0]           r_retire_count;

  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_load, w_result;
  logic                  w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_link     <= 1'b0;
      r_unsigned <= 1'b0;
      r_dest     <= '0;
      r_alu      <= '0;
      r_mem      <= '0;
      r_pc       <= '0;
      r_size     <= '0;
      r_off      <= '0;
    end else if (flush) begin
      // Zeroing the fields makes a killed slot read back as writereg=0, writedata=0.
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_link     <= 1'b0;
      r_unsigned <= 1'b0;
      r_dest     <= '0;
      r_alu      <= '0;
      r_mem      <= '0;
      r_pc       <= '0;
      r_size     <= '0;
      r_off      <= '0;
    end else if (!stall) begin
      r_valid    <= in_valid;
      r_regwrite <= in_regwrite;
      r_memtoreg <= in_memtoreg;
      r_link     <= in_link;
      r_unsigned <= in_load_unsigned;
      r_dest     <= in_dest;
      r_alu      <= in_alu_result;
      r_mem      <= in_mem_data;
      r_pc       <= in_pc;
      r_size     <= in_load_size;
      r_off      <= in_byte_off;
    end
  end

  // The held instruction retires when it leaves the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_retire_count <= '0;
    else if (r_valid && !stall && !flush)
      r_retire_count <= r_retire_count + 32'd1;
  end

  always_comb begin
    w_byte     = r_mem[8*r_off +: 8];
    w_half     = r_mem[16*r_off[1] +: 16];
    w_load     = r_mem;
    w_misalign = 1'b0;
    case (r_size)
      2'b00: w_load = r_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                 : {{(DATA_W-8){w_byte[7]}}, w_byte};
      2'b01: begin
        w_load     = r_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                : {{(DATA_W-16){w_half[15]}}, w_half};
        w_misalign = r_off[0];
      end
      default: w_misalign = (r_off != 2'b00);
    endcase
  end

  always_comb begin
    if (r_link)          w_result = r_pc + DATA_W'(LINK_OFFSET);
    else if (r_memtoreg) w_result = w_load;
    else                 w_result = r_alu;
  end

  assign wb_misalign  = r_valid & r_memtoreg & ~r_link & w_misalign;
  assign RegWrite     = r_valid & r_regwrite & (r_dest != '0) & ~wb_misalign;
  assign writereg     = r_dest;
  assign writedata    = w_result;
  assign retire_count = r_retire_count;

endmodule
